// File: rtl/rf_param_clken_pkg.sv
// Shared defaults and helpers for the rf_param_clken register file.
// Optional macro: RF_BYPASS_EN (same-edge write-to-read bypass).
package rf_param_clken_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_AW    = 3;
  localparam logic RST_BIT = 1'b0;

  function automatic int strb_w(int w);
    return w / 8;
  endfunction
endpackage

// File: rtl/rf_read_port.sv
// One synchronous read port: range/zero check, optional bypass merge.
// Optional macro: RF_BYPASS_EN.
module rf_read_port
  import rf_param_clken_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = DEF_AW,
  parameter int ZERO_REG = 0,
  localparam int SW      = strb_w(WIDTH)
) (
  input  logic                         clk_n,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         re,
  input  logic [AW-1:0]                raddr,
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
`ifdef RF_BYPASS_EN
  input  logic                         wr_ok,
  input  logic [AW-1:0]                waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic [SW-1:0]                wstrb,
`endif
  output logic [WIDTH-1:0]             rdata,
  output logic                         rvalid
);

  logic [WIDTH-1:0] word;

  // Unmatched addresses (out of range, or entry 0 when hardwired) read zero.
  always_comb begin
    word = {WIDTH{RST_BIT}};
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i) && !(ZERO_REG != 0 && i == 0))
        word = mem[i];
    end
`ifdef RF_BYPASS_EN
    if (wr_ok && waddr == raddr) begin
      for (int b = 0; b < SW; b++) begin
        if (wstrb[b])
          word[b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
`endif
  end

  always_ff @(posedge clk_n) begin
    if (rst) begin
      rdata  <= {WIDTH{RST_BIT}};
      rvalid <= 1'b0;
    end else if (clk_en) begin
      rvalid <= re;
      if (re)
        rdata <= word;
    end
  end

endmodule

// File: rtl/rf_param_clken.sv
// Clock-enabled DEPTH x WIDTH register file, byte-strobed write, two reads.
// Optional macro: RF_BYPASS_EN (colliding read returns post-write data).
module rf_param_clken
  import rf_param_clken_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = DEF_AW,
  parameter int ZERO_REG = 0,
  localparam int SW      = strb_w(WIDTH)
) (
  input  logic             clk_n,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [SW-1:0]    wstrb,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             rvalid_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_b
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic in_range;
  logic zero_hit;
  logic wr_ok;

  assign in_range = {1'b0, waddr} < DEPTH_V;
  assign zero_hit = (ZERO_REG != 0) && (waddr == '0);
  assign wr_ok    = clk_en && we && (|wstrb) && in_range && !zero_hit;

  always_ff @(posedge clk_n) begin
    if (rst) begin
      mem <= {DEPTH*WIDTH{RST_BIT}};
    end else if (wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int b = 0; b < SW; b++) begin
          if (waddr == AW'(i) && wstrb[b])
            mem[i][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  rf_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)
  ) u_port_a (
    .clk_n(clk_n), .rst(rst), .clk_en(clk_en),
    .re(re_a), .raddr(raddr_a), .mem(mem),
`ifdef RF_BYPASS_EN
    .wr_ok(wr_ok), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
`endif
    .rdata(rdata_a), .rvalid(rvalid_a)
  );

  rf_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)
  ) u_port_b (
    .clk_n(clk_n), .rst(rst), .clk_en(clk_en),
    .re(re_b), .raddr(raddr_b), .mem(mem),
`ifdef RF_BYPASS_EN
    .wr_ok(wr_ok), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
`endif
    .rdata(rdata_b), .rvalid(rvalid_b)
  );

endmodule

// File: tb/tb_rf_param_clken.sv
// Directed bench for rf_param_clken: default instance plus a
// ZERO_REG=1, DEPTH=6 instance sharing the same stimulus.
module tb_rf_param_clken;
  logic        clk_n = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  wstrb = '0;
  logic        re_a = 1'b0;
  logic [2:0]  raddr_a = '0;
  logic        re_b = 1'b0;
  logic [2:0]  raddr_b = '0;

  logic [15:0] rdata_a, rdata_b, z_rdata_a, z_rdata_b;
  logic        rvalid_a, rvalid_b, z_rvalid_a, z_rvalid_b;

  int checks = 0;
  int errors = 0;

  always #5 clk_n = ~clk_n;

  rf_param_clken dut (
    .clk_n(clk_n), .rst(rst), .clk_en(clk_en),
    .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b)
  );

  rf_param_clken #(.DEPTH(6), .ZERO_REG(1)) dut_z (
    .clk_n(clk_n), .rst(rst), .clk_en(clk_en),
    .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(z_rdata_a), .rvalid_a(z_rvalid_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(z_rdata_b), .rvalid_b(z_rvalid_b)
  );

  task automatic step();
    @(posedge clk_n);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d,
                    input logic [1:0] s);
    we = 1'b1; waddr = a; wdata = d; wstrb = s;
    step();
    we = 1'b0; wstrb = 2'b00;
  endtask

  task automatic rd_a(input logic [2:0] a);
    re_a = 1'b1; raddr_a = a;
    step();
    re_a = 1'b0;
  endtask

  initial begin
    logic [15:0] coll;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1357 + 16'(i), 2'b11);
    // reset wins over a same-edge write and read
    rst = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 16'hbeef; wstrb = 2'b11;
    re_a = 1'b1; raddr_a = 3'd1; re_b = 1'b1; raddr_b = 3'd2;
    step();
    rst = 1'b0; we = 1'b0; re_a = 1'b0; re_b = 1'b0;
    chk("rst_rdata_a", rdata_a, 16'h0000);
    chk("rst_rvalid_a", {15'd0, rvalid_a}, 16'd0);
    chk("rst_rdata_b", rdata_b, 16'h0000);
    chk("rst_rvalid_b", {15'd0, rvalid_b}, 16'd0);
    for (int i = 0; i < 8; i++) begin
      rd_a(3'(i));
      chk($sformatf("rst_entry%0d", i), rdata_a, 16'h0000);
      chk($sformatf("rst_valid%0d", i), {15'd0, rvalid_a}, 16'd1);
    end
    step();
    chk("idle_rvalid", {15'd0, rvalid_a}, 16'd0);

    // clock enable low: write and read both dropped
    clk_en = 1'b0; re_a = 1'b1; raddr_a = 3'd3;
    wr(3'd3, 16'h1111, 2'b11);
    clk_en = 1'b1; re_a = 1'b0;
    chk("cke_rvalid_hold", {15'd0, rvalid_a}, 16'd0);
    rd_a(3'd3);
    chk("cke_dropped_wr", rdata_a, 16'h0000);
    wr(3'd3, 16'h1111, 2'b11);
    rd_a(3'd3);
    chk("cke_wr", rdata_a, 16'h1111);
    chk("cke_wr_valid", {15'd0, rvalid_a}, 16'd1);

    // byte strobes
    wr(3'd5, 16'hdddd, 2'b11);
    wr(3'd5, 16'h4444, 2'b01);
    rd_a(3'd5);
    chk("strb_lo", rdata_a, 16'hdd44);
    wr(3'd5, 16'h0000, 2'b00);
    rd_a(3'd5);
    chk("strb_none", rdata_a, 16'hdd44);
    wr(3'd5, 16'h7777, 2'b10);
    rd_a(3'd5);
    chk("strb_hi", rdata_a, 16'h7744);

    // dual read
    wr(3'd1, 16'h2222, 2'b11);
    wr(3'd2, 16'h8888, 2'b11);
    re_a = 1'b1; raddr_a = 3'd1; re_b = 1'b1; raddr_b = 3'd2;
    step();
    chk("dual_a", rdata_a, 16'h2222);
    chk("dual_b", rdata_b, 16'h8888);
    chk("dual_va", {15'd0, rvalid_a}, 16'd1);
    chk("dual_vb", {15'd0, rvalid_b}, 16'd1);
    chk("z_dual_b", z_rdata_b, 16'h8888);
    re_a = 1'b0; re_b = 1'b0;
    step();
    chk("drop_va", {15'd0, rvalid_a}, 16'd0);
    chk("drop_vb", {15'd0, rvalid_b}, 16'd0);
    chk("hold_a", rdata_a, 16'h2222);
    chk("hold_b", rdata_b, 16'h8888);
    re_a = 1'b1; raddr_a = 3'd5; re_b = 1'b1; raddr_b = 3'd5;
    step();
    re_a = 1'b0; re_b = 1'b0;
    chk("same_addr_a", rdata_a, 16'h7744);
    chk("same_addr_b", rdata_b, 16'h7744);

    // read/write collision
    wr(3'd4, 16'hcccc, 2'b11);
    re_a = 1'b1; raddr_a = 3'd4;
    wr(3'd4, 16'hffff, 2'b11);
    re_a = 1'b0;
`ifdef RF_BYPASS_EN
    coll = 16'hffff;
`else
    coll = 16'hcccc;
`endif
    chk("collide", rdata_a, coll);
    rd_a(3'd4);
    chk("collide_after", rdata_a, 16'hffff);
    // discarded writes are never bypassed
    re_a = 1'b1; raddr_a = 3'd4;
    wr(3'd4, 16'h0000, 2'b00);
    re_a = 1'b0;
    chk("collide_nostrb", rdata_a, 16'hffff);

    // zero register and out-of-range addresses
    wr(3'd0, 16'hffff, 2'b11);
    rd_a(3'd0);
    chk("reg0_plain", rdata_a, 16'hffff);
    chk("reg0_zero", z_rdata_a, 16'h0000);
    re_a = 1'b1; raddr_a = 3'd0;
    wr(3'd0, 16'h5a5a, 2'b11);
    re_a = 1'b0;
    chk("reg0_zero_coll", z_rdata_a, 16'h0000);
    wr(3'd7, 16'habcd, 2'b11);
    rd_a(3'd7);
    chk("oor_plain", rdata_a, 16'habcd);
    chk("oor_zero", z_rdata_a, 16'h0000);
    chk("oor_valid", {15'd0, z_rvalid_a}, 16'd1);
    rd_a(3'd5);
    chk("oor_no_alias", z_rdata_a, 16'h7744);
    re_a = 1'b1; raddr_a = 3'd6;
    wr(3'd6, 16'h9999, 2'b11);
    re_a = 1'b0;
    chk("oor_no_bypass", z_rdata_a, 16'h0000);

    // reset mid-read discards the pending read
    re_a = 1'b1; raddr_a = 3'd4;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; re_a = 1'b0;
    chk("mid_rst_valid", {15'd0, rvalid_a}, 16'd0);
    chk("mid_rst_data", rdata_a, 16'h0000);
    rd_a(3'd4);
    chk("mid_rst_entry", rdata_a, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
